data_mem_responder: RTL and testbench
=====================================

DATA_MEM_RESPONDER -- requirements
Module: data_mem_responder

Interface
REQ-001 Parameter DEPTH_WORDS, default 1024: number of 32-bit words in the array.
REQ-002 Parameter WAIT_CYCLES, default 2: wait states inserted before each response; legal range 0..15.
REQ-003 clk  input  1  single clock; all state changes on its rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 i_addr  input  `ADDR_WIDTH  byte address from the memory stage.
REQ-006 i_addr_vld  input  1  request present; the initiator holds it high until it sees o_d_valid.
REQ-007 i_wr_en  input  1  1 = store, 0 = load.
REQ-008 i_sel  input  4  byte-lane enable; bit k = bits [8k+7:8k].
REQ-009 i_wdata  input  `N  store data, already lane-aligned.
REQ-010 o_rdata  output  `N  full word read; registered.
REQ-011 o_d_valid  output  1  one-cycle response pulse; registered.

Function
REQ-012 The block SHALL use the word index i_addr[`ADDR_WIDTH-1:2] and ignore i_addr[1:0]; it SHALL NOT shift data.
REQ-013 FSM states SHALL be IDLE, WAIT and RESP.
REQ-014 IDLE: if i_addr_vld=1, the block SHALL capture addr, wr_en, sel and wdata, and load the wait counter with WAIT_CYCLES.
REQ-015 IDLE transition: to WAIT if WAIT_CYCLES>0, else to RESP; otherwise stay in IDLE.
REQ-016 WAIT: the block SHALL decrement the counter each cycle and enter RESP on the cycle the counter reaches 0.
REQ-017 RESP: the block SHALL perform the access, assert o_d_valid=1 for exactly one cycle, and return to IDLE.
REQ-018 Latency: a request first sampled in IDLE at edge t SHALL produce o_d_valid high in cycle t+WAIT_CYCLES+1.
REQ-019 Store: the block SHALL write only the lanes whose i_sel bit is set; other lanes SHALL be unchanged; o_rdata SHALL hold its previous value.
REQ-020 Load: o_rdata SHALL be the full stored word regardless of i_sel; sign/zero extension belongs to the initiator.
REQ-021 o_rdata SHALL hold its value until the next load response.
REQ-022 Out-of-range (word index >= DEPTH_WORDS): a load SHALL return 0, a store SHALL be dropped, and o_d_valid SHALL still pulse.
REQ-023 Abort: if i_addr_vld falls while in WAIT, the block SHALL return to IDLE with no write and no o_d_valid.
REQ-024 Back-to-back: in the IDLE cycle right after RESP, a new request with i_addr_vld=1 SHALL be accepted, including one to the same address.
REQ-025 A load after a store to the same word SHALL return the merged data.
REQ-026 Inputs are sampled only in IDLE; changes during WAIT other than the REQ-023 abort SHALL be ignored.

Reset
REQ-027 While rst=1: state SHALL be IDLE, o_d_valid=0, o_rdata=0, counter=0.
REQ-028 rst asserted mid-WAIT or mid-RESP SHALL abort the access with no array write.
REQ-029 Array contents are not reset; after reset, reads of unwritten words are undefined.

Structure
REQ-030 `N, `ADDR_WIDTH and the B/H/W func3 codes SHALL come from the shared defines file; no local redefinition.
REQ-031 Storage SHALL be one sub-module, dmem_array: synchronous write with per-byte enables, and a read port.
REQ-032 The FSM, counter and capture registers SHALL reside in data_mem_responder.

Verification
REQ-033 Scenario 1, store then load (WAIT_CYCLES=2):
- store addr 0x10, sel 1111, data 0xDEADBEEF -> o_d_valid in cycle 3.
- then load addr 0x10 -> o_rdata=0xDEADBEEF with o_d_valid in cycle 3.
REQ-034 Scenario 2, byte store:
- store addr 0x10, sel 0001, data 0x000000AA over 0xDEADBEEF.
- load addr 0x13 -> o_rdata=0xDEADBEAA.
REQ-035 Scenario 3, WAIT_CYCLES=0: load -> o_d_valid in cycle 1.
REQ-036 Scenario 4, abort: i_addr_vld dropped in the first WAIT cycle of a store -> no o_d_valid, and the word is unchanged on the next load.
REQ-037 Scenario 5, out of range: store to word 1024 is dropped; load from word 1024 -> o_rdata=0 with o_d_valid=1.
REQ-038 Scenario 6, reset: rst pulsed during WAIT of a store -> o_d_valid=0, o_rdata=0, no write; the next request completes normally.

Source files
------------

// File: rtl/data_mem_responder_pkg.sv
// Shared word/address widths, load/store func3 codes and the responder FSM encoding.
// The defines live here so every file that imports the package sees a single definition.
`ifndef DATA_MEM_RESPONDER_DEFINES
`define DATA_MEM_RESPONDER_DEFINES
`define N          32
`define ADDR_WIDTH 32
`define F3_B       3'b000
`define F3_H       3'b001
`define F3_W       3'b010
`define F3_BU      3'b100
`define F3_HU      3'b101
`endif

package data_mem_responder_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      RESP = 2'd2
   } state_t;

   localparam int CNT_W   = 4;
   localparam int LANES   = `N / 8;
   localparam int IDX_W   = `ADDR_WIDTH - 2;

endpackage

// File: rtl/data_mem_responder_dmem_array.sv
// Word-organised storage: synchronous write with per-byte enables and a combinational read port.
// Contents are intentionally not reset.
module dmem_array #(
   parameter int DEPTH_WORDS = 1024,
   parameter int AW          = 10
) (
   input  logic            clk,
   input  logic [3:0]      we,
   input  logic [AW-1:0]   waddr,
   input  logic [`N-1:0]   wdata,
   input  logic [AW-1:0]   raddr,
   output logic [`N-1:0]   rdata
);

   logic [`N-1:0] mem [DEPTH_WORDS];

   always_ff @(posedge clk) begin
      for (int k = 0; k < 4; k++) begin
         if (we[k]) begin
            mem[waddr][8*k +: 8] <= wdata[8*k +: 8];
         end
      end
   end

   assign rdata = mem[raddr];

endmodule

// File: rtl/data_mem_responder.sv
// Wait-state data memory responder: captures a load/store in IDLE, waits WAIT_CYCLES,
// then answers with a single-cycle o_d_valid pulse. Stores commit at the end of RESP.
module data_mem_responder
   import data_mem_responder_pkg::*;
#(
   parameter int DEPTH_WORDS = 1024,
   parameter int WAIT_CYCLES = 2
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic [`ADDR_WIDTH-1:0] i_addr,
   input  logic                   i_addr_vld,
   input  logic                   i_wr_en,
   input  logic [3:0]             i_sel,
   input  logic [`N-1:0]          i_wdata,
   output logic [`N-1:0]          o_rdata,
   output logic                   o_d_valid,
   output logic [1:0]             dbg_state
);

   localparam int AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

   state_t             state, state_nxt;
   logic               enter_resp;
   logic [CNT_W-1:0]   cnt;
   logic [IDX_W-1:0]   cap_idx;
   logic               cap_wr;
   logic [3:0]         cap_sel;
   logic [`N-1:0]      cap_wdata;

   logic [IDX_W-1:0]   req_idx;
   logic               req_wr;
   logic               req_in_range;
   logic               cap_in_range;
   logic [3:0]         arr_we;
   logic [`N-1:0]      rd_word;
   logic               addr_unused;

   // Byte offset is irrelevant: data arrives lane-aligned and loads return the whole word.
   assign addr_unused = ^i_addr[1:0];

   // With zero wait states the response is set up straight from the live inputs.
   assign req_idx      = (state == IDLE) ? i_addr[`ADDR_WIDTH-1:2] : cap_idx;
   assign req_wr       = (state == IDLE) ? i_wr_en : cap_wr;
   assign req_in_range = req_idx < IDX_W'(DEPTH_WORDS);
   assign cap_in_range = cap_idx < IDX_W'(DEPTH_WORDS);
   // Write only on the edge that leaves RESP, so a reset during RESP drops the store.
   assign arr_we       = (state == RESP && cap_wr && cap_in_range) ? cap_sel : 4'b0000;
   assign dbg_state    = state;

   dmem_array #(
      .DEPTH_WORDS (DEPTH_WORDS),
      .AW          (AW)
   ) u_array (
      .clk   (clk),
      .we    (arr_we),
      .waddr (cap_idx[AW-1:0]),
      .wdata (cap_wdata),
      .raddr (req_idx[AW-1:0]),
      .rdata (rd_word)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt  = state;
      enter_resp = 1'b0;
      case (state)
         IDLE: begin
            if (i_addr_vld) begin
               if (WAIT_CYCLES == 0) begin
                  state_nxt  = RESP;
                  enter_resp = 1'b1;
               end else begin
                  state_nxt = WAIT;
               end
            end
         end
         WAIT: begin
            if (!i_addr_vld) begin
               state_nxt = IDLE;
            end else if (cnt == CNT_W'(1)) begin
               state_nxt  = RESP;
               enter_resp = 1'b1;
            end
         end
         RESP:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt       <= '0;
         cap_idx   <= '0;
         cap_wr    <= 1'b0;
         cap_sel   <= '0;
         cap_wdata <= '0;
         o_d_valid <= 1'b0;
         o_rdata   <= '0;
      end else begin
         o_d_valid <= enter_resp;
         if (state == IDLE && i_addr_vld) begin
            cap_idx   <= i_addr[`ADDR_WIDTH-1:2];
            cap_wr    <= i_wr_en;
            cap_sel   <= i_sel;
            cap_wdata <= i_wdata;
            cnt       <= CNT_W'(WAIT_CYCLES);
         end else if (state == WAIT) begin
            cnt <= i_addr_vld ? cnt - CNT_W'(1) : '0;
         end
         if (enter_resp && !req_wr) begin
            o_rdata <= req_in_range ? rd_word : '0;
         end
      end
   end

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed bench for data_mem_responder: a vector table on a 2-wait-state instance, a
// zero-wait instance, and hand sequences for abort and reset during WAIT / RESP.
module tb_data_mem_responder;

   logic        clk = 1'b0;
   logic        rst;
   always #5 clk = ~clk;

   logic [31:0] a_addr, a_wdata, a_rdata;
   logic        a_vld, a_wr, a_valid;
   logic [3:0]  a_sel;
   logic [1:0]  a_state;
   logic [31:0] b_addr, b_wdata, b_rdata;
   logic        b_vld, b_wr, b_valid;
   logic [3:0]  b_sel;
   logic [1:0]  b_state;

   data_mem_responder #(.DEPTH_WORDS(1024), .WAIT_CYCLES(2)) dut_a (
      .clk(clk), .rst(rst), .i_addr(a_addr), .i_addr_vld(a_vld), .i_wr_en(a_wr),
      .i_sel(a_sel), .i_wdata(a_wdata), .o_rdata(a_rdata), .o_d_valid(a_valid),
      .dbg_state(a_state));

   data_mem_responder #(.DEPTH_WORDS(1024), .WAIT_CYCLES(0)) dut_b (
      .clk(clk), .rst(rst), .i_addr(b_addr), .i_addr_vld(b_vld), .i_wr_en(b_wr),
      .i_sel(b_sel), .i_wdata(b_wdata), .o_rdata(b_rdata), .o_d_valid(b_valid),
      .dbg_state(b_state));

   typedef struct {
      logic [31:0] addr;
      logic        wr;
      logic [3:0]  sel;
      logic [31:0] wdata;
      logic [31:0] exp_rdata;
   } vec_t;

   vec_t        vecs [18];
   logic [31:0] exp_q [$];
   int          checks   = 0;
   int          failures = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   task automatic drive(input int unit, input logic [31:0] addr, input logic wr,
                        input logic [3:0] sel, input logic [31:0] wdata, input logic vld);
      if (unit == 0) begin
         a_addr = addr; a_wr = wr; a_sel = sel; a_wdata = wdata; a_vld = vld;
      end else begin
         b_addr = addr; b_wr = wr; b_sel = sel; b_wdata = wdata; b_vld = vld;
      end
   endtask

   function automatic logic valid_of(input int unit);
      return (unit == 0) ? a_valid : b_valid;
   endfunction

   function automatic logic [31:0] rdata_of(input int unit);
      return (unit == 0) ? a_rdata : b_rdata;
   endfunction

   // Called #1 after a rising edge; returns #1 after the edge that ends the response cycle.
   task automatic do_req(input int unit, input logic [31:0] addr, input logic wr,
                         input logic [3:0] sel, input logic [31:0] wdata, input int exp_lat,
                         input string tag, output logic [31:0] rd);
      int lat;
      lat = -1;
      rd  = '0;
      drive(unit, addr, wr, sel, wdata, 1'b1);
      for (int c = 0; c < 40; c++) begin
         @(negedge clk);
         if (valid_of(unit)) begin
            lat = c;
            rd  = rdata_of(unit);
            break;
         end
      end
      check({tag, "_latency"}, 32'(lat), 32'(exp_lat));
      @(posedge clk);
      #1;
      check({tag, "_pulse_one_cycle"}, 32'(valid_of(unit)), 32'd0);
      drive(unit, addr, wr, sel, wdata, 1'b0);
   endtask

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not reach the summary");
      $fatal(1, "timeout");
   end

   initial begin
      logic [31:0] rd;
      logic        seen;

      vecs[0]  = '{32'h0000_0010, 1'b1, 4'hF, 32'hDEAD_BEEF, 32'h0000_0000};
      vecs[1]  = '{32'h0000_0010, 1'b0, 4'hF, 32'h0000_0000, 32'hDEAD_BEEF};
      vecs[2]  = '{32'h0000_0010, 1'b1, 4'h1, 32'h0000_00AA, 32'hDEAD_BEEF};
      vecs[3]  = '{32'h0000_0013, 1'b0, 4'hF, 32'h0000_0000, 32'hDEAD_BEAA};
      vecs[4]  = '{32'h0000_0020, 1'b1, 4'hF, 32'h1122_3344, 32'hDEAD_BEAA};
      vecs[5]  = '{32'h0000_0022, 1'b1, 4'hC, 32'hAABB_0000, 32'hDEAD_BEAA};
      vecs[6]  = '{32'h0000_0020, 1'b0, 4'h0, 32'h0000_0000, 32'hAABB_3344};
      vecs[7]  = '{32'h0000_0024, 1'b1, 4'hF, 32'h5566_7788, 32'hAABB_3344};
      vecs[8]  = '{32'h0000_0025, 1'b1, 4'h2, 32'h0000_CC00, 32'hAABB_3344};
      vecs[9]  = '{32'h0000_0027, 1'b0, 4'hF, 32'h0000_0000, 32'h5566_CC88};
      vecs[10] = '{32'h0000_0000, 1'b1, 4'hF, 32'h0BAD_F00D, 32'h5566_CC88};
      vecs[11] = '{32'h0000_1000, 1'b1, 4'hF, 32'hFFFF_FFFF, 32'h5566_CC88};
      vecs[12] = '{32'h0000_0000, 1'b0, 4'hF, 32'h0000_0000, 32'h0BAD_F00D};
      vecs[13] = '{32'h0000_1000, 1'b0, 4'hF, 32'h0000_0000, 32'h0000_0000};
      vecs[14] = '{32'h0000_0FFC, 1'b1, 4'hF, 32'hCAFE_F00D, 32'h0000_0000};
      vecs[15] = '{32'h0000_0FFC, 1'b0, 4'hF, 32'h0000_0000, 32'hCAFE_F00D};
      vecs[16] = '{32'hFFFF_FFFC, 1'b0, 4'hF, 32'h0000_0000, 32'h0000_0000};
      vecs[17] = '{32'h0000_0010, 1'b0, 4'h0, 32'h0000_0000, 32'hDEAD_BEAA};

      // Clock / reset
      rst = 1'b1;
      drive(0, '0, 1'b0, 4'h0, '0, 1'b0);
      drive(1, '0, 1'b0, 4'h0, '0, 1'b0);
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("reset_a_valid", 32'(a_valid), 32'd0);
      check("reset_a_rdata", a_rdata, 32'd0);
      check("reset_a_state", 32'(a_state), 32'd0);
      check("reset_b_rdata", b_rdata, 32'd0);
      @(posedge clk);
      #1;
      rst = 1'b0;

      // Table: back-to-back requests on the 2-wait instance, latency WAIT_CYCLES+1 = 3
      for (int i = 0; i < 18; i++) begin
         exp_q.push_back(vecs[i].exp_rdata);
         do_req(0, vecs[i].addr, vecs[i].wr, vecs[i].sel, vecs[i].wdata, 3,
                $sformatf("vec%0d", i), rd);
         check($sformatf("vec%0d_rdata", i), rd, exp_q.pop_front());
      end

      // Zero wait states: response one cycle after the request
      do_req(1, 32'h40, 1'b1, 4'hF, 32'hA5A5_A5A5, 1, "w0_store", rd);
      check("w0_store_rdata_held", rd, 32'h0);
      do_req(1, 32'h40, 1'b0, 4'hF, 32'h0, 1, "w0_load", rd);
      check("w0_load_rdata", rd, 32'hA5A5_A5A5);
      do_req(1, 32'h43, 1'b1, 4'h8, 32'h5A00_0000, 1, "w0_byte_store", rd);
      do_req(1, 32'h41, 1'b0, 4'h1, 32'h0, 1, "w0_merge_load", rd);
      check("w0_merge_rdata", rd, 32'h5AA5_A5A5);

      // Abort: request dropped in the first WAIT cycle
      drive(0, 32'h10, 1'b1, 4'hF, 32'h9999_9999, 1'b1);
      @(posedge clk);
      #1;
      drive(0, 32'h10, 1'b1, 4'hF, 32'h9999_9999, 1'b0);
      seen = 1'b0;
      repeat (6) begin
         @(negedge clk);
         if (a_valid) seen = 1'b1;
      end
      check("abort_no_valid", 32'(seen), 32'd0);
      check("abort_state_idle", 32'(a_state), 32'd0);
      @(posedge clk);
      #1;
      do_req(0, 32'h10, 1'b0, 4'hF, 32'h0, 3, "abort_reload", rd);
      check("abort_word_unchanged", rd, 32'hDEAD_BEAA);

      // Reset while a store sits in WAIT
      drive(0, 32'h10, 1'b1, 4'hF, 32'h7777_7777, 1'b1);
      @(posedge clk);
      #1;
      check("rst_wait_in_wait", 32'(a_state), 32'd1);
      rst = 1'b1;
      drive(0, 32'h10, 1'b1, 4'hF, 32'h7777_7777, 1'b0);
      @(negedge clk);
      check("rst_wait_valid", 32'(a_valid), 32'd0);
      check("rst_wait_rdata", a_rdata, 32'd0);
      check("rst_wait_state", 32'(a_state), 32'd0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      do_req(0, 32'h10, 1'b0, 4'hF, 32'h0, 3, "rst_wait_reload", rd);
      check("rst_wait_no_write", rd, 32'hDEAD_BEAA);

      // Reset during the RESP cycle of a store
      drive(0, 32'h10, 1'b1, 4'hF, 32'h6666_6666, 1'b1);
      seen = 1'b0;
      for (int c = 0; c < 10; c++) begin
         @(negedge clk);
         if (a_valid) begin
            seen = 1'b1;
            break;
         end
      end
      check("rst_resp_reached", 32'(seen), 32'd1);
      rst = 1'b1;
      drive(0, 32'h10, 1'b1, 4'hF, 32'h6666_6666, 1'b0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      check("rst_resp_rdata", a_rdata, 32'd0);
      do_req(0, 32'h10, 1'b0, 4'hF, 32'h0, 3, "rst_resp_reload", rd);
      check("rst_resp_no_write", rd, 32'hDEAD_BEAA);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
